// File: rtl/traffic_light_monitor.sv
// Safety monitor between a two-direction traffic light controller and its lamp drivers.
// Optional yellow-duration checks (codes 4/5) are compiled in with `define TLM_YEL_CHECK_EN.
module traffic_light_monitor #(
  parameter int unsigned YEL_MIN    = 2,
  parameter int unsigned YEL_MAX    = 5,
  parameter int unsigned FLASH_HALF = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [2:0] in_1,
  input  logic [2:0] in_2,
  output logic [2:0] lamp_1,
  output logic [2:0] lamp_2,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] YEL = 3'b001;

  typedef enum logic {NORMAL, FAULT} state_t;

  state_t           state;
  logic [2:0]       prev_1, prev_2;
  logic             prev_valid;
  logic             flash;
  logic [CNT_W-1:0] flash_cnt;
  logic             short_yel, long_yel;
  logic [2:0]       viol_code;

  function automatic logic one_hot(input logic [2:0] w);
    return (w == RED) || (w == GRN) || (w == YEL);
  endfunction

  function automatic logic bad_step(input logic [2:0] p, input logic [2:0] c);
    return (p != c) && !(p == GRN && c == YEL) && !(p == YEL && c == RED)
                    && !(p == RED && c == GRN);
  endfunction

`ifdef TLM_YEL_CHECK_EN
  logic [CNT_W-1:0] yel_cnt_1, yel_cnt_2;

  // A nonzero count already implies the previous sample was yellow.
  function automatic logic [CNT_W-1:0] yel_next(input logic [2:0] c, input logic [CNT_W-1:0] n);
    if (c != YEL) return '0;
    if (n == CNT_W'(YEL_MAX + 1)) return n;
    return n + 1'b1;
  endfunction

  always_comb begin
    short_yel = prev_valid &&
                ((prev_1 == YEL && in_1 == RED && yel_cnt_1 < CNT_W'(YEL_MIN)) ||
                 (prev_2 == YEL && in_2 == RED && yel_cnt_2 < CNT_W'(YEL_MIN)));
    long_yel  = (in_1 == YEL && yel_cnt_1 == CNT_W'(YEL_MAX)) ||
                (in_2 == YEL && yel_cnt_2 == CNT_W'(YEL_MAX));
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      yel_cnt_1 <= '0;
      yel_cnt_2 <= '0;
    end else begin
      yel_cnt_1 <= yel_next(in_1, yel_cnt_1);
      yel_cnt_2 <= yel_next(in_2, yel_cnt_2);
    end
  end
`else
  logic [CNT_W-1:0] yel_bounds_unused;
  assign yel_bounds_unused = CNT_W'(YEL_MIN + YEL_MAX);
  assign short_yel = 1'b0;
  assign long_yel  = 1'b0;
`endif

  always_comb begin
    viol_code = 3'd0;
    if (!one_hot(in_1) || !one_hot(in_2))
      viol_code = 3'd1;
    else if (in_1 != RED && in_2 != RED)
      viol_code = 3'd2;
    else if (prev_valid && (bad_step(prev_1, in_1) || bad_step(prev_2, in_2)))
      viol_code = 3'd3;
    else if (short_yel)
      viol_code = 3'd4;
    else if (long_yel)
      viol_code = 3'd5;
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state      <= NORMAL;
      lamp_1     <= RED;
      lamp_2     <= RED;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      flash      <= 1'b0;
      flash_cnt  <= '0;
      prev_1     <= RED;
      prev_2     <= RED;
      prev_valid <= 1'b0;
    end else begin
      prev_1     <= in_1;
      prev_2     <= in_2;
      prev_valid <= 1'b1;
      case (state)
        NORMAL: begin
          if (viol_code != 3'd0) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= viol_code;
            flash      <= 1'b1;
            flash_cnt  <= '0;
            lamp_1     <= YEL;
            lamp_2     <= YEL;
          end else begin
            lamp_1 <= in_1;
            lamp_2 <= in_2;
          end
        end
        FAULT: begin
          // Lamps carry the next flash value so they stay in step with the flash register.
          if (flash_cnt == CNT_W'(FLASH_HALF - 1)) begin
            flash     <= ~flash;
            flash_cnt <= '0;
            lamp_1    <= {2'b00, ~flash};
            lamp_2    <= {2'b00, ~flash};
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
            lamp_1    <= {2'b00, flash};
            lamp_2    <= {2'b00, flash};
          end
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: history-based model checked every cycle
// plus directed literal expectations.
module tb_traffic_light_monitor;

  localparam int unsigned YEL_MIN    = 2;
  localparam int unsigned YEL_MAX    = 5;
  localparam int unsigned FLASH_HALF = 1;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b001;

  logic       clk = 1'b0;
  logic       rs  = 1'b1;
  logic [2:0] in_1 = R, in_2 = R;
  logic [2:0] lamp_1, lamp_2, fault_code;
  logic       fault;

  int tests  = 0;
  int failed = 0;

  traffic_light_monitor #(
    .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .FLASH_HALF(FLASH_HALF), .CNT_W(8)
  ) dut (
    .clk(clk), .rs(rs), .in_1(in_1), .in_2(in_2),
    .lamp_1(lamp_1), .lamp_2(lamp_2), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] h1[$], h2[$];
  bit         m_fault;
  int         m_code, m_age;
  logic [2:0] m_lamp_1, m_lamp_2;

  function automatic int phase(input logic [2:0] w);
    return (w == R) ? 0 : (w == G) ? 1 : 2;
  endfunction

  function automatic bit legal_word(input logic [2:0] w);
    return $countones(w) == 1;
  endfunction

  // Phases cycle R(0) -> G(1) -> Y(2) -> R; staying put is also allowed.
  function automatic bit legal_move(input logic [2:0] p, input logic [2:0] c);
    return phase(c) == phase(p) || phase(c) == (phase(p) + 1) % 3;
  endfunction

  function automatic int trail_y(input logic [2:0] q[$]);
    int n = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] != Y) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit too_short(input logic [2:0] q[$], input logic [2:0] c);
    return q.size() > 0 && q[q.size()-1] == Y && c == R && trail_y(q) < int'(YEL_MIN);
  endfunction

  function automatic bit too_long(input logic [2:0] q[$], input logic [2:0] c);
    return c == Y && trail_y(q) + 1 == int'(YEL_MAX) + 1;
  endfunction

  always @(posedge clk) begin
    logic [2:0] a, b;
    int code;
    a = in_1;
    b = in_2;
    if (rs) begin
      h1.delete(); h2.delete();
      m_fault = 0; m_code = 0; m_age = 0;
      m_lamp_1 = R; m_lamp_2 = R;
    end else begin
      if (m_fault) begin
        m_age++;
        m_lamp_1 = {2'b00, 1'((m_age / int'(FLASH_HALF)) % 2 == 0)};
        m_lamp_2 = m_lamp_1;
      end else begin
        code = 0;
        if (!legal_word(a) || !legal_word(b)) code = 1;
        else if (a != R && b != R) code = 2;
        else if (h1.size() > 0 && (!legal_move(h1[h1.size()-1], a) ||
                                   !legal_move(h2[h2.size()-1], b))) code = 3;
`ifdef TLM_YEL_CHECK_EN
        else if (too_short(h1, a) || too_short(h2, b)) code = 4;
        else if (too_long(h1, a) || too_long(h2, b)) code = 5;
`endif
        if (code != 0) begin
          m_fault = 1; m_code = code; m_age = 0;
          m_lamp_1 = Y; m_lamp_2 = Y;
        end else begin
          m_lamp_1 = a; m_lamp_2 = b;
        end
      end
      h1.push_back(a);
      h2.push_back(b);
    end
    #1;
    chk("model_lamp_1", lamp_1, m_lamp_1);
    chk("model_lamp_2", lamp_2, m_lamp_2);
    chk("model_fault", {2'b00, fault}, {2'b00, m_fault});
    chk("model_code", fault_code, 3'(m_code));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    in_1 = a;
    in_2 = b;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rs = 1'b1;
    @(posedge clk);
    #2;
    rs = 1'b0;
  endtask

  task automatic legal_cycle(input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < 12; i++)
        step(i < 3 ? G : (i < 6 ? Y : R), i < 6 ? R : (i < 9 ? G : Y));
  endtask

  initial begin
    do_reset();
    chk("reset_lamp_1", lamp_1, 3'b100);
    chk("reset_lamp_2", lamp_2, 3'b100);
    chk("reset_fault", {2'b00, fault}, 3'd0);
    chk("reset_code", fault_code, 3'd0);

    legal_cycle(2);
    chk("legal_fault", {2'b00, fault}, 3'd0);
    chk("legal_lamp_2", lamp_2, Y);
    step(G, R);
    chk("legal_lamp_1", lamp_1, G);

    // Bad encoding then flash sequence
    do_reset();
    step(G, R);
    step(3'b110, R);
    chk("enc_fault", {2'b00, fault}, 3'd1);
    chk("enc_code", fault_code, 3'd1);
    chk("enc_lamp_1", lamp_1, 3'b001);
    chk("enc_lamp_2", lamp_2, 3'b001);
    step(G, G);
    chk("flash_off", lamp_1, 3'b000);
    chk("flash_code_frozen", fault_code, 3'd1);
    step(R, R);
    chk("flash_on", lamp_2, 3'b001);
    step(R, R);
    chk("flash_off2", lamp_1, 3'b000);

    // Reset mid-fault, then a legal run
    do_reset();
    chk("rst_mid_lamp", lamp_1, 3'b100);
    chk("rst_mid_fault", {2'b00, fault}, 3'd0);
    chk("rst_mid_code", fault_code, 3'd0);
    legal_cycle(1);
    chk("after_rst_fault", {2'b00, fault}, 3'd0);

    do_reset();
    step(G, G);
    chk("conflict_code", fault_code, 3'd2);

    do_reset();
    step(3'b000, G);
    chk("priority_code", fault_code, 3'd1);

    do_reset();
    step(G, R);
    step(R, R);
    chk("trans_code", fault_code, 3'd3);
    chk("trans_lamp", lamp_1, 3'b001);

    do_reset();
    step(G, R);
    do_reset();
    step(R, R);
    chk("first_sample_fault", {2'b00, fault}, 3'd0);

    // Yellow bounds
    do_reset();
    step(G, R);
    step(Y, R);
    step(R, R);
`ifdef TLM_YEL_CHECK_EN
    chk("short_yel_code", fault_code, 3'd4);
`else
    chk("short_yel_nofault", {2'b00, fault}, 3'd0);
`endif

    do_reset();
    step(G, R);
    for (int i = 0; i < 5; i++) step(Y, R);
    chk("yel5_nofault", {2'b00, fault}, 3'd0);
    step(Y, R);
`ifdef TLM_YEL_CHECK_EN
    chk("long_yel_code", fault_code, 3'd5);
`else
    chk("long_yel_nofault", {2'b00, fault}, 3'd0);
`endif

    // Yellow on the first sample after reset starts its run at 1
    do_reset();
    step(Y, R);
    step(R, R);
`ifdef TLM_YEL_CHECK_EN
    chk("first_yel_short", fault_code, 3'd4);
`else
    chk("first_yel_nofault", fault_code, 3'd0);
`endif

    step(R, R);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
